// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath widths, the fetch-buffer entry
// layout and the canonical NOP that decode substitutes on bubbles.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Handshake bundle around the fetch stage: PC request in, instruction memory
// request/response, flush, and the decode-side entry output.
interface instr_fetch_if #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int ILEN = riscv_pkg::ILEN
);

  logic            pc_valid;
  logic [XLEN-1:0] pc_in;
  logic            pc_ready;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] id_instr;

  // Environment side: PC source, memory, redirect logic and decode.
  modport master (
    output pc_valid, pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           flush, id_ready,
    input  pc_ready, imem_req_valid, imem_addr, id_valid, id_pc, id_instr
  );

  // Fetch-stage side.
  modport slave (
    input  pc_valid, pc_in, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           flush, id_ready,
    output pc_ready, imem_req_valid, imem_addr, id_valid, id_pc, id_instr
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; the head entry is read straight
// from the storage array so it is stable until popped.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [PW-1:0] PTR_ONE = PW'(32'd1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push_s, do_pop_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and storage; clear wins over traffic.
  always_comb begin
    do_pop_s  = pop & ~empty & ~clear;
    do_push_s = push & ~clear & (~full | do_pop_s);
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (do_push_s && (wr_ptr_q == PW'(i))) ? din : mem_q[i];
    end
    if (clear) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      wr_ptr_d = do_push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_pop_s  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is zeroed on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: credit-limited request pass-through, in-order
// response pairing with a PC queue, and a fetch buffer feeding decode.
module instr_fetch #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int ILEN       = riscv_pkg::ILEN,
  parameter int FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.slave bus
);

  localparam int              CW         = $clog2(FIFO_DEPTH + 1);
  localparam int              DW         = $clog2(2 * FIFO_DEPTH + 1);
  localparam logic [CW:0]     DEPTH_C    = (CW + 1)'(FIFO_DEPTH);
  localparam logic [DW-1:0]   DROP_ZERO  = {DW{1'b0}};
  localparam logic [DW-1:0]   DROP_ONE   = DW'(32'd1);

  logic                 credit_ok_s, req_fire_s, take_s, drop_hit_s;
  logic                 consumed_s, id_valid_s, pop_s;
  logic [CW-1:0]        pcq_count_s, fb_count_s;
  logic                 pcq_full_s, pcq_empty_s, fb_full_s, fb_empty_s;
  logic [XLEN-1:0]      pcq_head_s;
  logic [XLEN+ILEN-1:0] fb_head_s;
  logic [DW-1:0]        drop_q, drop_d;

  // The PC queue occupancy is the count of live outstanding requests; flushed
  // ones move into drop_q so credit only ever counts fetches that will land.
  always_comb begin
    credit_ok_s = (({1'b0, fb_count_s} + {1'b0, pcq_count_s}) < DEPTH_C)
                  & ~pcq_full_s & ~fb_full_s;
    req_fire_s  = bus.pc_valid & bus.imem_req_ready & credit_ok_s & ~bus.flush;
    drop_hit_s  = bus.imem_rsp_valid & (drop_q != DROP_ZERO);
    consumed_s  = drop_hit_s | (bus.imem_rsp_valid & ~pcq_empty_s);
    take_s      = bus.imem_rsp_valid & ~bus.flush & (drop_q == DROP_ZERO)
                  & ~pcq_empty_s;
    id_valid_s  = ~fb_empty_s & ~bus.flush;
    pop_s       = id_valid_s & bus.id_ready;
  end

  // Responses owed to flushed requests; stray responses leave it untouched.
  always_comb begin
    if (bus.flush) begin
      drop_d = drop_q + DW'(pcq_count_s) - (consumed_s ? DROP_ONE : DROP_ZERO);
    end else if (drop_hit_s) begin
      drop_d = drop_q - DROP_ONE;
    end else begin
      drop_d = drop_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= DROP_ZERO;
    end else begin
      drop_q <= drop_d;
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.flush),
    .push  (req_fire_s),
    .pop   (take_s),
    .din   (bus.pc_in),
    .dout  (pcq_head_s),
    .full  (pcq_full_s),
    .empty (pcq_empty_s),
    .count (pcq_count_s)
  );

  sync_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(FIFO_DEPTH)) u_fetch_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.flush),
    .push  (take_s),
    .pop   (pop_s),
    .din   ({pcq_head_s, bus.imem_rsp_data}),
    .dout  (fb_head_s),
    .full  (fb_full_s),
    .empty (fb_empty_s),
    .count (fb_count_s)
  );

  assign bus.pc_ready       = bus.imem_req_ready & credit_ok_s & ~bus.flush;
  assign bus.imem_req_valid = bus.pc_valid & credit_ok_s & ~bus.flush;
  assign bus.imem_addr      = bus.pc_in;
  assign bus.id_valid       = id_valid_s;
  assign bus.id_pc          = fb_head_s[XLEN+ILEN-1:ILEN];
  assign bus.id_instr       = fb_head_s[ILEN-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch, checked against an
// epoch-based transaction model of the fetch stage and its memory.
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if #(.XLEN(32), .ILEN(32)) bus ();

  instr_fetch #(.XLEN(32), .ILEN(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        infl[$];
  ent_t        fq[$];
  logic [31:0] delivered[$];

  int checks = 0, errors = 0, cyc = 0, epoch = 0, fires = 0;
  int lat_min = 1, lat_max = 1;
  bit auto_pc = 1'b0, stray_en = 1'b0, fixed_en = 1'b0;
  logic [31:0] fixed_instr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Live (not flushed) requests still waiting for memory.
  function automatic int cur_out();
    int n = 0;
    foreach (infl[i]) if (infl[i].epoch == epoch) n++;
    return n;
  endfunction

  // One clock: drive memory response, check outputs, advance the model.
  task automatic cycle();
    bit   credit, exp_ready, exp_reqv, exp_idv, fire, rsp_real;
    ent_t e;
    req_t r;
    rsp_real = (infl.size() != 0) && (infl[0].due <= cyc);
    if (rsp_real) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = infl[0].instr;
    end else if (stray_en && infl.size() == 0 && $urandom_range(7, 0) == 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = $urandom;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    #2;
    credit    = (fq.size() + cur_out()) < DEPTH;
    exp_ready = bus.imem_req_ready && credit && !bus.flush;
    exp_reqv  = bus.pc_valid && credit && !bus.flush;
    exp_idv   = (fq.size() != 0) && !bus.flush;
    chk("pc_ready", 32'(bus.pc_ready), 32'(exp_ready));
    chk("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_reqv));
    chk("id_valid", 32'(bus.id_valid), 32'(exp_idv));
    if (exp_idv) begin
      chk("id_pc", bus.id_pc, fq[0].pc);
      chk("id_instr", bus.id_instr, fq[0].instr);
    end
    fire = bus.pc_valid && exp_ready;
    if (exp_idv && bus.id_ready) begin
      delivered.push_back(fq[0].pc);
      fq.delete(0);
    end
    if (rsp_real) begin
      if (infl[0].epoch == epoch && !bus.flush) begin
        e.pc    = infl[0].pc;
        e.instr = infl[0].instr;
        fq.push_back(e);
      end
      infl.delete(0);
    end
    if (fire) begin
      r.pc    = bus.pc_in;
      r.instr = fixed_en ? fixed_instr : $urandom;
      r.epoch = epoch;
      r.due   = cyc + int'($urandom_range(lat_max, lat_min));
      infl.push_back(r);
      fires++;
    end
    if (bus.flush) begin
      fq.delete();
      epoch++;
    end
    cyc++;
    @(posedge clk);
    #1;
    if (fire && auto_pc) bus.pc_in = bus.pc_in + 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    bus.pc_valid       = 1'b0;
    bus.pc_in          = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.flush          = 1'b0;
    bus.id_ready       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_id_instr", bus.id_instr, 32'h0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_pc_ready", 32'(bus.pc_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch, response two cycles after the request.
    fixed_en = 1'b1; fixed_instr = 32'h0050_0093; lat_min = 2; lat_max = 2;
    bus.imem_req_ready = 1'b1; bus.pc_valid = 1'b1; bus.pc_in = 32'h0;
    cycle();
    bus.pc_valid = 1'b0; fixed_en = 1'b0;
    cycle();
    cycle();
    chk("single_valid", 32'(bus.id_valid), 32'd1);
    chk("single_pc", bus.id_pc, 32'h0);
    chk("single_instr", bus.id_instr, 32'h0050_0093);
    bus.id_ready = 1'b1;
    cycle();
    bus.id_ready = 1'b0;

    // Credit limit with decode stalled.
    lat_min = 1; lat_max = 1; auto_pc = 1'b1; bus.pc_in = 32'h0;
    bus.pc_valid = 1'b1; fires = 0;
    repeat (6) cycle();
    chk("credit_two_fired", 32'(fires), 32'd2);
    bus.id_ready = 1'b1;
    cycle();
    chk("credit_no_fire_on_pop", 32'(fires), 32'd2);
    bus.id_ready = 1'b0;
    cycle();
    chk("credit_third_after_pop", 32'(fires), 32'd3);
    bus.pc_valid = 1'b0; bus.id_ready = 1'b1;
    repeat (6) cycle();

    // Streaming eight PCs through a one-cycle memory.
    delivered.delete(); fires = 0; bus.pc_in = 32'h0;
    for (int i = 0; i < 40; i++) begin
      bus.pc_valid = (fires < 8);
      cycle();
    end
    chk("stream_count", 32'(delivered.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < delivered.size()) chk("stream_order", delivered[i], 32'(4 * i));
    end

    // Flush with two fetches in flight, then redirect to 0x100.
    delivered.delete(); fires = 0; lat_min = 3; lat_max = 3; bus.pc_in = 32'h40;
    for (int i = 0; i < 4 && fires < 2; i++) begin
      bus.pc_valid = 1'b1;
      cycle();
    end
    chk("flush_inflight", 32'(fires), 32'd2);
    bus.pc_valid = 1'b0; bus.flush = 1'b1;
    #1;
    chk("flush_id_valid_low", 32'(bus.id_valid), 32'd0);
    chk("flush_pc_ready_low", 32'(bus.pc_ready), 32'd0);
    cycle();
    bus.flush = 1'b0; lat_min = 1; lat_max = 1; bus.pc_in = 32'h100; fires = 0;
    for (int i = 0; i < 12; i++) begin
      bus.pc_valid = (fires < 1);
      cycle();
    end
    chk("flush_count", 32'(delivered.size()), 32'd1);
    if (delivered.size() > 0) chk("flush_first_pc", delivered[0], 32'h100);

    // Flush coinciding with a response and a pop, one request outstanding.
    delivered.delete(); fires = 0; bus.id_ready = 1'b0; bus.pc_in = 32'h200;
    bus.pc_valid = 1'b1;
    cycle();
    cycle();
    chk("coinc_fired", 32'(fires), 32'd2);
    bus.pc_valid = 1'b0; bus.flush = 1'b1; bus.id_ready = 1'b1;
    cycle();
    bus.flush = 1'b0;
    repeat (3) cycle();
    chk("coinc_nothing", 32'(delivered.size()), 32'd0);
    bus.pc_in = 32'h300; bus.pc_valid = 1'b1;
    cycle();
    bus.pc_valid = 1'b0;
    repeat (4) cycle();
    chk("coinc_after_count", 32'(delivered.size()), 32'd1);
    if (delivered.size() > 0) chk("coinc_after_pc", delivered[0], 32'h300);

    // Randomized traffic with flushes, variable latency and stray responses.
    auto_pc = 1'b0; stray_en = 1'b1; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      bus.pc_valid       = ($urandom_range(3, 0) != 0);
      bus.pc_in          = $urandom & 32'hFFFF_FFFC;
      bus.imem_req_ready = ($urandom_range(3, 0) != 0);
      bus.id_ready       = ($urandom_range(4, 0) < 3);
      bus.flush          = ($urandom_range(19, 0) == 0);
      cycle();
    end
    bus.flush = 1'b0; stray_en = 1'b0; bus.pc_valid = 1'b0;
    bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    repeat (8) cycle();

    // Asynchronous reset with the fetch buffer full.
    auto_pc = 1'b1; bus.pc_in = 32'h500; lat_min = 1; lat_max = 1;
    bus.id_ready = 1'b0; bus.pc_valid = 1'b1;
    repeat (5) cycle();
    chk("prerst_full_valid", 32'(bus.id_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("arst_id_pc", bus.id_pc, 32'h0);
    chk("arst_id_instr", bus.id_instr, 32'h0);
    fq.delete(); infl.delete(); epoch++;
    bus.pc_valid = 1'b0;
    #1;
    chk("arst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fires = 0; delivered.delete(); bus.pc_in = 32'h600; bus.id_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.pc_valid = (fires < 4);
      cycle();
    end
    chk("postrst_count", 32'(delivered.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < delivered.size()) chk("postrst_order", delivered[i], 32'h600 + 32'(4 * i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage directly downstream of the program-counter block.
- Accepts fetch addresses via a valid/ready handshake and issues them to instruction memory.
- Pairs each in-order memory response with its PC and buffers {pc, instr} in a small FIFO that feeds decode.
- Supports a single-cycle flush (branch/jump redirect) that discards buffered and in-flight fetches.

Parameters:
- XLEN, 32, address/PC width.
- ILEN, 32, instruction width.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, >= 2; also the limit on fetches in flight.

Ports:
- clk input 1: clock.
- rst_n input 1: reset, asynchronous, active-low.
- pc_valid input 1: upstream PC is valid.
- pc_in input XLEN: fetch address.
- pc_ready output 1: fetch address accepted this cycle.
- imem_req_valid output 1: memory request valid.
- imem_req_ready input 1: memory accepts request.
- imem_addr output XLEN: request address.
- imem_rsp_valid input 1: response valid; responses return in order, with no back-pressure.
- imem_rsp_data input ILEN: fetched instruction.
- flush input 1: discard all buffered and in-flight fetches.
- id_valid output 1: decode-side entry valid.
- id_ready input 1: decode accepts entry.
- id_pc output XLEN: PC of head entry.
- id_instr output ILEN: instruction of head entry.

Behaviour:
- Counters:
  - fifo_count: 0..FIFO_DEPTH.
  - outstanding: requests accepted by memory, response not yet received and not dropped.
  - drop: responses still to be discarded, 0..2*FIFO_DEPTH.
- Credit: credit_ok = (fifo_count + outstanding) < FIFO_DEPTH. Counted from registered values; same-cycle pops do not add credit.
- Request path is combinational pass-through:
  - imem_req_valid = pc_valid & credit_ok & !flush
  - imem_addr = pc_in
  - pc_ready = imem_req_ready & credit_ok & !flush
- Request fire:
  - Occurs when pc_valid & pc_ready.
  - pc_in is pushed into a PC queue (depth FIFO_DEPTH); outstanding is incremented.
- Response handling (imem_rsp_valid):
  - If drop > 0: the response is discarded and drop is decremented.
  - Otherwise: pop the PC queue head, push {pc, imem_rsp_data} into the fetch FIFO, decrement outstanding.
  - A response arriving while outstanding == 0 and drop == 0 is a protocol error: ignored, no state change.
- Output:
  - id_valid = (fifo_count != 0) & !flush.
  - id_pc and id_instr come from the head register; they hold stable while id_valid & !id_ready.
  - Pop occurs when id_valid & id_ready.
  - Latency: a response at cycle N is visible on id_* at cycle N+1.
- Simultaneous push and pop with the FIFO full or empty is legal; fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Flush, effective on the cycle it is asserted:
  - Fetch FIFO and PC queue are cleared (pointers and counts = 0).
  - drop_next = drop + outstanding + (request fire ? 1 : 0, always 0 because pc_ready is low) − (rsp consumed this cycle ? 1 : 0).
  - outstanding_next = 0.
  - A response in the flush cycle is discarded and accounted as above.
  - No request or pop fires during flush.
  - Back-to-back flushes accumulate into drop correctly.
- After flush: new requests may issue on the next cycle while drop > 0. Their responses follow the dropped ones (in order) and are stored normally.
- Reset (async assert, sync deassert by system):
  - All counters and pointers = 0.
  - id_valid = 0, id_pc = 0, id_instr = 0.
  - pc_ready and imem_req_valid are 0 whenever credit_ok would be computed from reset state while pc_valid = 0.
  - Reset mid-operation drops everything; no responses are expected after reset.

Decomposition:
- Shared package riscv_pkg:
  - XLEN and ILEN constants.
  - A fetch-entry typedef {pc, instr}.
  - NOP encoding 32'h00000013, used by decode on bubbles.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop, full/empty, clear). Instantiated twice:
  - PC queue: width XLEN.
  - Fetch buffer: width XLEN+ILEN.

Test Plan:
- Reset then single fetch:
  - Stimulus: pc_in = 0x0, req_ready = 1, rsp 0x00500093 two cycles later.
  - Required: id_valid = 1 next cycle with id_pc = 0x0, id_instr = 0x00500093.
- Credit limit:
  - Stimulus: id_ready = 0, pc_valid held, PCs 0x0/0x4/0x8, responses prompt.
  - Required: exactly 2 requests fire; pc_ready stays 0 until a pop; the third request fires the cycle after the first pop.
- Streaming:
  - Stimulus: id_ready = 1, req_ready = 1, 1-cycle memory, PCs 0x0..0x1C.
  - Required: 8 entries in order, no loss or duplication, steady-state one entry every FIFO_DEPTH-limited cycle.
- Flush with 2 in flight:
  - Stimulus: 2 outstanding, flush = 1, then new PC 0x100.
  - Required: next 2 responses discarded; first id entry is id_pc = 0x100; id_valid = 0 during the flush cycle.
- Flush coincident with response and pop:
  - Stimulus: flush, rsp_valid and id_ready all high with 1 outstanding.
  - Required: drop stays 0; FIFO empty; no entry is delivered.
- Async reset mid-stream:
  - Stimulus: rst_n low with FIFO full.
  - Required: id_valid drops immediately; all counters = 0; fetch resumes correctly after release.
